// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase types, lamp patterns and counter widths
//
// Purpose: common definitions for the traffic phase timer and its request latch.
// Contents: phase_t enum, lamp-pattern constants, counter widths, lamp decoder.

package traffic_pkg;

   typedef enum logic [2:0] {
      NS_GREEN,
      NS_YELLOW,
      EW_GREEN,
      EW_YELLOW,
      ILLEGAL
   } phase_t;

   // Lamp vector bit order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
   localparam logic [5:0] LAMP_NS_G = 6'b001100;
   localparam logic [5:0] LAMP_NS_Y = 6'b010100;
   localparam logic [5:0] LAMP_EW_G = 6'b100001;
   localparam logic [5:0] LAMP_EW_Y = 6'b100010;

   localparam int NS_W = 5;
   localparam int EW_W = 4;
   localparam int Y_W  = 2;

   // Any lamp combination other than the four legal ones is ILLEGAL
   // (covers all-dark, both-green, multiple lamps per direction, etc.).
   function automatic phase_t decode_phase(input logic [5:0] lamps);
      phase_t ph;
      case (lamps)
         LAMP_NS_G: ph = NS_GREEN;
         LAMP_NS_Y: ph = NS_YELLOW;
         LAMP_EW_G: ph = EW_GREEN;
         LAMP_EW_Y: ph = EW_YELLOW;
         default:   ph = ILLEGAL;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/traffic_req_latch.sv
// rtl/traffic_req_latch.sv - loop-detector synchroniser plus set/clear request flop
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   raw     in   asynchronous loop-detector input
//   service in   one-cycle clear (phase entry of the served direction)
//   req     out  latched vehicle request

module traffic_req_latch
   import traffic_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic service,
   output logic req
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic req_q,   req_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      req_d   = req_q;
      if (sync2_q) begin
         req_d = 1'b1;
      end
      // Clear wins over a coincident set; a still-present vehicle
      // re-sets the request on the following cycle.
      if (service) begin
         req_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         req_q   <= req_d;
      end
   end

   assign req = req_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - phase counters, tick prescaler and vehicle requests for the lamp controller
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ns_red/yellow/green              NS lamp state from the controller
//   ew_red/yellow/green              EW lamp state from the controller
//   ns_vehicle_raw, ew_vehicle_raw   asynchronous loop detectors
//   ns_counter [4:0]                 NS-green elapsed ticks
//   ew_counter [3:0]                 EW-green elapsed ticks
//   yellow_counter [1:0]             yellow elapsed ticks (either direction)
//   ns/ew_vehicle_detect             latched requests
//   tick                             one-clk pulse every TICK_DIV clks
//   fault                            sticky illegal-lamp flag

module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 4,
   parameter int PRE_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ns_red,
   input  logic            ns_yellow,
   input  logic            ns_green,
   input  logic            ew_red,
   input  logic            ew_yellow,
   input  logic            ew_green,
   input  logic            ns_vehicle_raw,
   input  logic            ew_vehicle_raw,
   output logic [NS_W-1:0] ns_counter,
   output logic [EW_W-1:0] ew_counter,
   output logic [Y_W-1:0]  yellow_counter,
   output logic            ns_vehicle_detect,
   output logic            ew_vehicle_detect,
   output logic            tick,
   output logic            fault
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick_q, tick_d;
   logic             fault_q, fault_d;
   phase_t           prev_q, prev_d;
   logic [NS_W-1:0]  ns_q, ns_d;
   logic [EW_W-1:0]  ew_q, ew_d;
   logic [Y_W-1:0]   y_q, y_d;

   logic [5:0] lamps;
   phase_t     phase;
   logic       entry;
   logic       ns_service;
   logic       ew_service;

   assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
   assign phase = decode_phase(lamps);

   // ILLEGAL is never an entry; leaving ILLEGAL into any legal phase is,
   // because prev_q then holds ILLEGAL.
   assign entry      = (phase != prev_q) && (phase != ILLEGAL);
   assign ns_service = entry && (phase == NS_GREEN);
   assign ew_service = entry && (phase == EW_GREEN);

   always_comb begin
      pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      tick_d  = (pre_q == PRE_LAST);
      fault_d = fault_q | (phase == ILLEGAL);
      prev_d  = phase;
      ns_d    = ns_q;
      ew_d    = ew_q;
      y_d     = y_q;

      if (phase == ILLEGAL) begin
         ns_d = '0;
         ew_d = '0;
         y_d  = '0;
      end else if (entry) begin
         // Entry clear beats a coincident tick.
         case (phase)
            NS_GREEN:             ns_d = '0;
            EW_GREEN:             ew_d = '0;
            NS_YELLOW, EW_YELLOW: y_d  = '0;
            default:              ;
         endcase
      end else if (tick_q) begin
         // Free-running wrap so the controller re-evaluates at each pass through max.
         case (phase)
            NS_GREEN:             ns_d = ns_q + NS_W'(1);
            EW_GREEN:             ew_d = ew_q + EW_W'(1);
            NS_YELLOW, EW_YELLOW: y_d  = y_q + Y_W'(1);
            default:              ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         tick_q  <= 1'b0;
         fault_q <= 1'b0;
         prev_q  <= NS_GREEN;   // matches the controller's power-up phase
         ns_q    <= '0;
         ew_q    <= '0;
         y_q     <= '0;
      end else begin
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         fault_q <= fault_d;
         prev_q  <= prev_d;
         ns_q    <= ns_d;
         ew_q    <= ew_d;
         y_q     <= y_d;
      end
   end

   traffic_req_latch u_ns_req (
      .clk     (clk),
      .rst     (rst),
      .raw     (ns_vehicle_raw),
      .service (ns_service),
      .req     (ns_vehicle_detect)
   );

   traffic_req_latch u_ew_req (
      .clk     (clk),
      .rst     (rst),
      .raw     (ew_vehicle_raw),
      .service (ew_service),
      .req     (ew_vehicle_detect)
   );

   assign ns_counter     = ns_q;
   assign ew_counter     = ew_q;
   assign yellow_counter = y_q;
   assign tick           = tick_q;
   assign fault          = fault_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - self-checking bench for traffic_phase_timer

module tb_traffic_phase_timer;

   localparam int TICK_DIV = 4;
   localparam int P_NSG = 0, P_NSY = 1, P_EWG = 2, P_EWY = 3, P_ILL = 4;
   localparam logic [5:0] L_NSG = 6'b001100;
   localparam logic [5:0] L_NSY = 6'b010100;
   localparam logic [5:0] L_EWG = 6'b100001;
   localparam logic [5:0] L_EWY = 6'b100010;
   localparam logic [5:0] L_BAD = 6'b101100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] lamps = 6'b001100;
   logic       ns_vehicle_raw = 1'b0;
   logic       ew_vehicle_raw = 1'b0;
   logic [4:0] ns_counter;
   logic [3:0] ew_counter;
   logic [1:0] yellow_counter;
   logic       ns_vehicle_detect;
   logic       ew_vehicle_detect;
   logic       tick;
   logic       fault;

   int tests = 0;
   int fails = 0;

   traffic_phase_timer #(.TICK_DIV(TICK_DIV), .PRE_W(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .ns_red            (lamps[5]),
      .ns_yellow         (lamps[4]),
      .ns_green          (lamps[3]),
      .ew_red            (lamps[2]),
      .ew_yellow         (lamps[1]),
      .ew_green          (lamps[0]),
      .ns_vehicle_raw    (ns_vehicle_raw),
      .ew_vehicle_raw    (ew_vehicle_raw),
      .ns_counter        (ns_counter),
      .ew_counter        (ew_counter),
      .yellow_counter    (yellow_counter),
      .ns_vehicle_detect (ns_vehicle_detect),
      .ew_vehicle_detect (ew_vehicle_detect),
      .tick              (tick),
      .fault             (fault)
   );

   always #5 clk = ~clk;

   // Reference model: cycle count since reset, counters as integers
   // indexed by owner (0 NS green, 1 EW green, 2 yellow), modulo wrap.
   int m_cnt [3];
   int m_mod [3] = '{32, 16, 4};
   int m_cyc;
   int m_prev;
   bit m_tick;
   bit m_fault;
   bit m_det [2];
   bit m_s1 [2];
   bit m_s2 [2];

   function automatic int decode(logic [5:0] l);
      if (l == L_NSG) return P_NSG;
      if (l == L_NSY) return P_NSY;
      if (l == L_EWG) return P_EWG;
      if (l == L_EWY) return P_EWY;
      return P_ILL;
   endfunction

   function automatic int owner(int ph);
      if (ph == P_NSG) return 0;
      if (ph == P_EWG) return 1;
      return 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      for (int d = 0; d < 2; d++) begin
         m_det[d] = 0; m_s1[d] = 0; m_s2[d] = 0;
      end
      m_cyc = 0; m_prev = P_NSG; m_tick = 0; m_fault = 0;
   endtask

   task automatic model_update();
      int  ph;
      bit  entry;
      bit  raw [2];
      ph    = decode(lamps);
      entry = (ph != m_prev) && (ph != P_ILL);
      raw[0] = ns_vehicle_raw;
      raw[1] = ew_vehicle_raw;
      if (ph == P_ILL) begin
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end else if (entry) begin
         m_cnt[owner(ph)] = 0;
      end else if (m_tick) begin
         m_cnt[owner(ph)] = (m_cnt[owner(ph)] + 1) % m_mod[owner(ph)];
      end
      for (int d = 0; d < 2; d++) begin
         if (entry && ph == ((d == 0) ? P_NSG : P_EWG)) m_det[d] = 0;
         else if (m_s2[d]) m_det[d] = 1;
         m_s2[d] = m_s1[d];
         m_s1[d] = raw[d];
      end
      if (ph == P_ILL) m_fault = 1;
      m_prev = ph;
      m_cyc++;
      m_tick = (m_cyc % TICK_DIV) == 0;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("model ns_counter", 32'(ns_counter), 32'(m_cnt[0]));
      check("model ew_counter", 32'(ew_counter), 32'(m_cnt[1]));
      check("model yellow_counter", 32'(yellow_counter), 32'(m_cnt[2]));
      check("model ns_detect", 32'(ns_vehicle_detect), 32'(m_det[0]));
      check("model ew_detect", 32'(ew_vehicle_detect), 32'(m_det[1]));
      check("model tick", 32'(tick), 32'(m_tick));
      check("model fault", 32'(fault), 32'(m_fault));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_model();
   endtask

   typedef struct {
      logic [5:0] lamps;
      int         hold;
      int         e_ns;
      int         e_ew;
      int         e_y;
      logic       e_tick;
   } vec_t;

   vec_t vecs [16];

   initial begin
      // Cumulative clock counts after release: 1,4,5,128,129,200,...
      vecs[0]  = '{L_NSG,   1,  0,  0, 0, 1'b0};
      vecs[1]  = '{L_NSG,   3,  0,  0, 0, 1'b1};
      vecs[2]  = '{L_NSG,   1,  1,  0, 0, 1'b0};
      vecs[3]  = '{L_NSG, 123, 31,  0, 0, 1'b1};
      vecs[4]  = '{L_NSG,   1,  0,  0, 0, 1'b0};
      vecs[5]  = '{L_NSG,  71, 17,  0, 0, 1'b1};
      vecs[6]  = '{L_NSY,   1, 17,  0, 0, 1'b0};
      vecs[7]  = '{L_NSY,  12, 17,  0, 3, 1'b0};
      vecs[8]  = '{L_EWG,   1, 17,  0, 3, 1'b0};
      vecs[9]  = '{L_EWG,  59, 17, 15, 3, 1'b0};
      vecs[10] = '{L_EWG,   8, 17,  1, 3, 1'b0};
      vecs[11] = '{L_EWY,   1, 17,  1, 0, 1'b0};
      vecs[12] = '{L_EWY,   4, 17,  1, 1, 1'b0};
      vecs[13] = '{L_NSY,   2, 17,  1, 0, 1'b1};
      vecs[14] = '{L_EWY,   1, 17,  1, 0, 1'b0};
      vecs[15] = '{L_EWY,   4, 17,  1, 1, 1'b0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset ns_counter", 32'(ns_counter), 0);
      check("reset ew_counter", 32'(ew_counter), 0);
      check("reset yellow_counter", 32'(yellow_counter), 0);
      check("reset detects", 32'({ns_vehicle_detect, ew_vehicle_detect}), 0);
      check("reset tick", 32'(tick), 0);
      check("reset fault", 32'(fault), 0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         lamps = vecs[i].lamps;
         repeat (vecs[i].hold) step();
         check($sformatf("vec%0d ns_counter", i), 32'(ns_counter), 32'(vecs[i].e_ns));
         check($sformatf("vec%0d ew_counter", i), 32'(ew_counter), 32'(vecs[i].e_ew));
         check($sformatf("vec%0d yellow_counter", i), 32'(yellow_counter), 32'(vecs[i].e_y));
         check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].e_tick));
      end

      // Single-clock EW detector pulse during NS green, then EW entry clears.
      lamps = L_NSG;
      step();
      ew_vehicle_raw = 1'b1;
      step();
      ew_vehicle_raw = 1'b0;
      check("ew pulse edge1", 32'(ew_vehicle_detect), 0);
      step();
      check("ew pulse edge2", 32'(ew_vehicle_detect), 0);
      step();
      check("ew pulse edge3", 32'(ew_vehicle_detect), 1);
      repeat (5) step();
      check("ew pulse held", 32'(ew_vehicle_detect), 1);
      lamps = L_EWG;
      step();
      check("ew entry clear", 32'(ew_vehicle_detect), 0);
      step();
      check("ew stays clear", 32'(ew_vehicle_detect), 0);

      // Raw held through the entry: clear wins, then re-set next clock.
      lamps = L_EWY;
      step();
      ew_vehicle_raw = 1'b1;
      repeat (3) step();
      check("ew held set", 32'(ew_vehicle_detect), 1);
      lamps = L_EWG;
      step();
      check("ew held entry clear", 32'(ew_vehicle_detect), 0);
      step();
      check("ew held re-set", 32'(ew_vehicle_detect), 1);
      ew_vehicle_raw = 1'b0;

      // Run EW green to ew_counter=9, then reset asynchronously mid-phase.
      begin
         int guard = 0;
         while (m_cnt[1] != 9 && guard < 200) begin
            step();
            guard++;
         end
         check("reach ew 9 within budget", 32'(guard < 200), 1);
      end
      check("ew before reset", 32'(ew_counter), 9);
      #2 rst = 1'b1;
      #1;
      check("async rst ew_counter", 32'(ew_counter), 0);
      check("async rst detects", 32'({ns_vehicle_detect, ew_vehicle_detect}), 0);
      check("async rst tick/fault", 32'({tick, fault}), 0);
      model_reset();
      rst = 1'b0;
      step();
      check("post-rst ew entry", 32'(ew_counter), 0);
      repeat (2) step();
      check("post-rst no early tick", 32'(tick), 0);
      step();
      check("post-rst first tick", 32'(tick), 1);
      step();
      check("post-rst ew count", 32'(ew_counter), 1);

      // Illegal lamps: fault sticky, counters zero, resume as an entry.
      lamps = L_BAD;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("illegal fault c%0d", i), 32'(fault), 1);
         check($sformatf("illegal counters c%0d", i),
               32'({ns_counter, ew_counter, yellow_counter}), 0);
      end
      lamps = L_NSG;
      step();
      check("resume ns from 0", 32'(ns_counter), 0);
      check("fault sticky", 32'(fault), 1);

      // Randomized phases, occasional illegal patterns, random detectors.
      begin
         int left = 0;
         for (int c = 0; c < 3000; c++) begin
            if (left == 0) begin
               int pick = $urandom_range(0, 19);
               case (pick % 5)
                  0: lamps = L_NSG;
                  1: lamps = L_NSY;
                  2: lamps = L_EWG;
                  3: lamps = L_EWY;
                  default: lamps = (pick == 19) ? 6'($urandom) : L_NSG;
               endcase
               left = $urandom_range(1, 150);
            end
            left--;
            if ($urandom_range(0, 7) == 0) ns_vehicle_raw = ~ns_vehicle_raw;
            if ($urandom_range(0, 7) == 0) ew_vehicle_raw = ~ew_vehicle_raw;
            if (c == 1500) begin
               #2 rst = 1'b1;
               #1 model_reset();
               rst = 1'b0;
            end
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
